// File: rtl/timer_periph.sv
// timer_periph -- memory-mapped interval timer on the MIPS data-memory bus.
//
// Register map (word offsets from BASE_ADDR):
//   +0x0  TH       reload value
//   +0x4  TL       up-counter, reloads from TH on overflow
//   +0x8  TCON     {irq_status, irq_enable, count_enable}, zero-extended on read
//   +0xC  SYSTICK  free-running cycle counter (only with TIMER_SYSTICK_EN)
//
// Optional feature macro: TIMER_SYSTICK_EN. When undefined, BASE+0xC still
// decodes as a hit but reads as zero and ignores stores.

module timer_periph #(
   parameter int unsigned PRESCALE  = 1,
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        mem_write,
   input  logic        mem_read,
   output logic [31:0] rdata,
   output logic        hit,
   output logic        irq
);

   // Prescaler terminal count; PRESCALE=65536 maps onto 16'hFFFF.
   localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

   localparam logic [1:0] SEL_TH      = 2'd0;
   localparam logic [1:0] SEL_TL      = 2'd1;
   localparam logic [1:0] SEL_TCON    = 2'd2;
   localparam logic [1:0] SEL_SYSTICK = 2'd3;

   // Architectural state
   logic [31:0] th;
   logic [31:0] tl;
   logic [2:0]  tcon;
   logic [15:0] pcnt;

   // Next-state values
   logic [31:0] th_next;
   logic [31:0] tl_next;
   logic [2:0]  tcon_next;
   logic [15:0] pcnt_next;
   logic        irq_next;

   // Decode and event signals
   logic [29:0] word_offset;
   logic [1:0]  reg_sel;
   logic        wr_th;
   logic        wr_tl;
   logic        wr_tcon;
   logic        tick;
   logic        wrap;
   logic        irq_set;
   logic [31:0] systick_rd;
   logic        unused_addr_bits;

   // Byte lanes are irrelevant: the block only supports whole-word access.
   assign unused_addr_bits = ^addr[1:0];

   // Word-granular decode; the subtraction lets BASE_ADDR sit on any word
   // boundary, not just a 16-byte aligned one.
   assign word_offset = addr[31:2] - BASE_ADDR[31:2];
   assign hit         = (word_offset[29:2] == 28'd0);
   assign reg_sel     = word_offset[1:0];

   assign wr_th   = mem_write && hit && (reg_sel == SEL_TH);
   assign wr_tl   = mem_write && hit && (reg_sel == SEL_TL);
   assign wr_tcon = mem_write && hit && (reg_sel == SEL_TCON);

   // Prescaler advance, tick detection and overflow-set decision. A store to
   // TL in the same cycle as a tick swallows the whole tick, including any
   // interrupt it would have raised.
   always_comb begin
      tick      = tcon[0] && (pcnt == PCNT_LAST);
      pcnt_next = pcnt;
      if (tcon[0]) begin
         pcnt_next = tick ? 16'd0 : pcnt + 16'd1;
      end
      wrap    = tick && (tl == 32'hFFFF_FFFF) && !wr_tl;
      irq_set = wrap && tcon[1];
   end

   // Register next-state: CPU stores win over counting, reload bypasses a
   // concurrent TH store, and a pending overflow interrupt is never lost to a
   // concurrent TCON store.
   always_comb begin
      th_next   = th;
      tl_next   = tl;
      tcon_next = tcon;

      if (wr_th) begin
         th_next = wdata;
      end

      if (wr_tl) begin
         tl_next = wdata;
      end else if (wrap) begin
         tl_next = wr_th ? wdata : th;
      end else if (tick) begin
         tl_next = tl + 32'd1;
      end

      if (wr_tcon) begin
         tcon_next = wdata[2:0];
      end
      if (irq_set) begin
         tcon_next[2] = 1'b1;
      end

      irq_next = tcon_next[1] && tcon_next[2];
   end

   // State registers; reset clears everything immediately, mid-count included.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         th   <= 32'h0;
         tl   <= 32'h0;
         tcon <= 3'b000;
         pcnt <= 16'h0;
         irq  <= 1'b0;
      end else begin
         th   <= th_next;
         tl   <= tl_next;
         tcon <= tcon_next;
         pcnt <= pcnt_next;
         irq  <= irq_next;
      end
   end

`ifdef TIMER_SYSTICK_EN
   logic [31:0] systick;

   // Free-running cycle counter, independent of TCON, wraps modulo 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         systick <= 32'h0;
      end else begin
         systick <= systick + 32'd1;
      end
   end

   assign systick_rd = systick;
`else
   assign systick_rd = 32'h0;
`endif

   // Combinational load path; drives zero when not selected so the bus mux
   // can simply OR slave outputs if it wants to.
   always_comb begin
      rdata = 32'h0;
      if (mem_read && hit) begin
         case (reg_sel)
            SEL_TH:      rdata = th;
            SEL_TL:      rdata = tl;
            SEL_TCON:    rdata = {29'h0, tcon};
            SEL_SYSTICK: rdata = systick_rd;
            default:     rdata = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_periph.sv
// tb_timer_periph -- scoreboard bench for timer_periph (PRESCALE=4).
// Honours TIMER_SYSTICK_EN the same way as the design.

module tb_timer_periph;

   localparam int unsigned P    = 4;
   localparam logic [31:0] BASE = 32'h4000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        mem_write = 1'b0;
   logic        mem_read = 1'b0;
   logic [31:0] rdata;
   logic        hit;
   logic        irq;

   timer_periph #(.PRESCALE(P), .BASE_ADDR(BASE)) dut (
      .clk(clk),
      .reset(reset),
      .addr(addr),
      .wdata(wdata),
      .mem_write(mem_write),
      .mem_read(mem_read),
      .rdata(rdata),
      .hit(hit),
      .irq(irq)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        hit;
      logic        irq;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;

   // Reference model state: plain numbers advanced once per clock edge
   logic [31:0] m_th, m_tl, m_systick;
   logic [2:0]  m_tcon;
   int unsigned m_pcnt;
   logic        m_irq;

   logic [31:0] r_addr, r_data, r_exp;
   logic        r_wr, r_rd;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_hit(input logic [31:0] a);
      logic [31:0] off;
      off = {a[31:2], 2'b00} - BASE;
      return off < 32'd16;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [31:0] off;
      off = {a[31:2], 2'b00} - BASE;
      if (off >= 32'd16) return 32'h0;
      case (off / 4)
         0: return m_th;
         1: return m_tl;
         2: return {29'h0, m_tcon};
`ifdef TIMER_SYSTICK_EN
         default: return m_systick;
`else
         default: return 32'h0;
`endif
      endcase
   endfunction

   task automatic model_reset();
      m_th = 0; m_tl = 0; m_tcon = 0; m_pcnt = 0; m_irq = 0; m_systick = 0;
   endtask

   // One clock edge of the timer's documented behaviour.
   task automatic model_step(input logic wr, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] off, new_th, new_tl;
      logic [2:0]  new_tcon;
      logic        wr_hit, is_tick, raise;
      int          which;
      if (reset) begin
         model_reset();
         return;
      end
      off    = {a[31:2], 2'b00} - BASE;
      wr_hit = wr && (off < 32'd16);
      which  = int'(off / 4);
      is_tick = m_tcon[0] && (m_pcnt == P - 1);
      if (m_tcon[0]) m_pcnt = (m_pcnt + 1) % P;
      new_th = m_th; new_tl = m_tl; new_tcon = m_tcon; raise = 0;
      if (is_tick && !(wr_hit && which == 1)) begin
         if (m_tl == 32'hFFFF_FFFF) begin
            new_tl = (wr_hit && which == 0) ? d : m_th;
            raise  = m_tcon[1];
         end else begin
            new_tl = m_tl + 1;
         end
      end
      if (wr_hit) begin
         if (which == 0) new_th = d;
         if (which == 1) new_tl = d;
         if (which == 2) new_tcon = d[2:0];
      end
      if (raise) new_tcon[2] = 1'b1;
      m_th = new_th; m_tl = new_tl; m_tcon = new_tcon;
      m_irq = new_tcon[1] & new_tcon[2];
      m_systick = m_systick + 1;
   endtask

   // Drive one bus cycle, queue what the DUT must show during it, then step
   // the model across the following edge. use_exp substitutes a fixed value.
   task automatic apply_stimulus(input logic wr, input logic rd, input logic [31:0] a,
                                 input logic [31:0] d, input logic use_exp, input logic [31:0] exp_val);
      exp_t e;
      mem_write = wr; mem_read = rd; addr = a; wdata = d;
      e.hit   = model_hit(a);
      e.rdata = (rd && e.hit) ? model_read(a) : 32'h0;
      if (use_exp) e.rdata = exp_val;
      e.irq   = m_irq;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      model_step(wr, a, d);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      model_reset();
      apply_stimulus(0, 0, 32'h0, 32'h0, 0, 0);
      reset = 1'b0;
   endtask

   // Monitor: compare whatever the DUT presents mid-cycle against the queue
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         check_output("rdata", rdata, mon_e.rdata);
         check_output("hit", {31'h0, hit}, {31'h0, mon_e.hit});
         check_output("irq", {31'h0, irq}, {31'h0, mon_e.irq});
      end
   end

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      // Reads while held in reset
      for (int i = 0; i < 4; i++) apply_stimulus(0, 1, BASE + 32'(i * 4), 0, 1, 32'h0);
      reset = 1'b0;

      // Prescaler freeze/resume: enable at edge 0, disable at 6, enable at 10
      apply_stimulus(1, 0, BASE + 32'h8, 32'h1, 0, 0);
      for (int k = 1; k <= 13; k++) begin
         if (k == 6 || k == 10) begin
            apply_stimulus(1, 0, BASE + 32'h8, (k == 6) ? 32'h0 : 32'h1, 0, 0);
         end else begin
            r_exp = (k <= 4) ? 32'd0 : ((k <= 12) ? 32'd1 : 32'd2);
            apply_stimulus(0, 1, BASE + 32'h4, 0, 1, r_exp);
         end
      end

      // Overflow, reload, interrupt and same-edge collisions
      pulse_reset();
      apply_stimulus(1, 0, BASE, 32'hFFFF_FFFC, 0, 0);
      apply_stimulus(1, 0, BASE + 32'h4, 32'hFFFF_FFFE, 0, 0);
      for (int c = 0; c <= 40; c++) begin
         case (c)
            0, 10, 24, 26: apply_stimulus(1, 0, BASE + 32'h8, 32'h3, 0, 0);
            28:            apply_stimulus(1, 0, BASE + 32'h4, 32'd7, 0, 0);
            30:            apply_stimulus(1, 0, BASE + 32'h4, 32'hFFFF_FFFF, 0, 0);
            32:            apply_stimulus(1, 0, BASE, 32'd9, 0, 0);
            5, 8:          apply_stimulus(0, 1, BASE + 32'h4, 0, 1, 32'hFFFF_FFFF);
            9:             apply_stimulus(0, 1, BASE + 32'h4, 0, 1, 32'hFFFF_FFFC);
            25:            apply_stimulus(0, 1, BASE + 32'h8, 0, 1, 32'h7);
            27:            apply_stimulus(0, 1, BASE + 32'h8, 0, 1, 32'h3);
            29:            apply_stimulus(0, 1, BASE + 32'h4, 0, 1, 32'd7);
            33:            apply_stimulus(0, 1, BASE + 32'h4, 0, 1, 32'd9);
            default:       apply_stimulus(0, 1, BASE + ((c % 2 == 0) ? 32'h4 : 32'h8), 0, 0, 0);
         endcase
      end

      // Asynchronous reset mid-count, between clock edges
      mem_write = 1'b0; mem_read = 1'b1; addr = BASE + 32'h4;
      #2;
      reset = 1'b1;
      #1;
      check_output("async_rst_rdata", rdata, 32'h0);
      check_output("async_rst_irq", {31'h0, irq}, 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) apply_stimulus(0, 1, BASE + 32'(i * 4), 0, 1, 32'h0);
      reset = 1'b0;

      // SYSTICK after 100 edges; stores to SYSTICK and unmapped space ignored
      for (int k = 1; k <= 100; k++) begin
         if (k == 50)      apply_stimulus(1, 0, BASE + 32'hC, 32'h1234_5678, 0, 0);
         else if (k == 60) apply_stimulus(1, 0, BASE + 32'h10, 32'hDEAD_BEEF, 0, 0);
         else              apply_stimulus(0, 0, BASE, 0, 0, 0);
      end
`ifdef TIMER_SYSTICK_EN
      apply_stimulus(0, 1, BASE + 32'hC, 0, 1, 32'd100);
`else
      apply_stimulus(0, 1, BASE + 32'hC, 0, 1, 32'd0);
`endif
      apply_stimulus(0, 1, BASE + 32'h10, 0, 1, 32'h0);
      apply_stimulus(0, 1, BASE - 32'h4, 0, 1, 32'h0);

      // Randomised traffic against the model
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 7))
            0:       r_addr = BASE + 32'h10 + 32'($urandom_range(0, 3) * 4);
            1:       r_addr = BASE - 32'h4;
            default: r_addr = BASE + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
         endcase
         case ($urandom_range(0, 3))
            0:       r_data = $urandom;
            1:       r_data = 32'h3 | 32'($urandom_range(0, 7));
            default: r_data = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         endcase
         r_wr = ($urandom_range(0, 3) == 0);
         r_rd = ($urandom_range(0, 9) < 6);
         apply_stimulus(r_wr, r_rd, r_addr, r_data, 0, 0);
      end

      apply_stimulus(0, 0, 32'h0, 32'h0, 0, 0);
      @(negedge clk);
      #1;
      check_output("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_periph.md
# timer_periph

Memory-mapped interval timer that runs on the divided processor clock produced by the clock generator. It sits on the MIPS pipeline's data-memory bus next to data RAM and is accessed by the MEM stage through load/store words. It counts up in TL, reloads from TH on overflow and raises a level interrupt request toward the pipeline's exception logic.

## Interface
- PRESCALE, 1: number of enabled clk cycles per TL increment; legal range 1..65536.
- BASE_ADDR, 32'h4000_0000: word address of TH; TL = BASE+4, TCON = BASE+8, SYSTICK = BASE+C.
- clk  in  1  processor clock (divided clock from the clock generator).
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  byte address from MEM stage; bits [1:0] ignored.
- wdata  in  32  store data.
- mem_write  in  1  store strobe, sampled on posedge clk.
- mem_read  in  1  load strobe, qualifies rdata.
- rdata  out  32  load data, combinational.
- hit  out  1  addr decodes to this block (BASE..BASE+C); combinational, used by the bus mux.
- irq  out  1  interrupt request, registered level.

## Operation
- Registers: TH[31:0] reload value; TL[31:0] counter; TCON[2:0] = {irq_status, irq_enable, count_enable}.
- Write: mem_write & hit loads the addressed register on posedge clk; TCON takes wdata[2:0]; writes to SYSTICK or unmapped offsets are ignored.
- Read: rdata = addressed register when mem_read & hit, else 32'h0; TCON reads zero-extended.
- Prescaler: 16-bit pcnt counts only while TCON[0]=1; a tick occurs when pcnt == PRESCALE-1, after which pcnt returns to 0. Clearing TCON[0] freezes pcnt (it does not reset it). PRESCALE=1 ticks every enabled cycle.
- On tick: if TL == 32'hFFFF_FFFF then TL <= TH and, if TCON[1]=1, TCON[2] <= 1; otherwise TL <= TL+1 (modulo 2^32).
- irq <= TCON[1] & TCON[2] (registered from next-state values, so irq rises in the same edge TCON[2] sets).
- Software clears the interrupt by writing TCON with bit2=0.
- Simultaneous events, same edge:
  - CPU write to TL and tick: write wins, the tick is dropped.
  - CPU write to TH and overflow reload: TL takes the new wdata (bypass), TH takes wdata.
  - CPU write to TCON and overflow with irq_enable: TCON[2] <= wdata[2] | 1, i.e. the interrupt is never lost; enable bits take wdata[1:0], and the set condition uses the old TCON[1].
- Reset (any time, including mid-count): TH=0, TL=0, TCON=0, pcnt=0, irq=0, SYSTICK=0. It takes effect immediately with no clock required.

## Timing
- Write-to-visible: 1 cycle; a load in the cycle after a store returns the new value.
- Read latency: 0 cycles (combinational from addr/mem_read).
- With PRESCALE=P and TCON[0] set at edge E, the first TL increment occurs at edge E+P.
- Overflow-to-irq: irq is high after the same edge that reloads TL.
- Interrupt period with TCON enabled, P=1: (2^32 - TH) cycles between reloads.

## Configuration
- TIMER_SYSTICK_EN defined: a 32-bit free-running SYSTICK counter increments every clk cycle from reset, independent of TCON. It wraps modulo 2^32 and reads at BASE+C.
- Not defined: there is no SYSTICK register, reads of BASE+C return 32'h0, and hit still covers BASE+C.

## Test plan
- Reset mid-count (TL=5, TCON=3'b011, assert reset asynchronously) -> all registers, rdata of every offset and irq read 0 immediately.
- TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFE, TCON=3'b011, P=1 -> TL goes to FFFF_FFFF then FFFF_FFFC; irq high after the 2nd edge; period 4 cycles thereafter.
- Store TCON=3'b011 in the same edge as an overflow -> TCON reads 3'b111 and irq stays 1; a subsequent store of 3'b011 with no overflow drops irq the next edge.
- PRESCALE=4, TL=0, enable at edge 0, disable at edge 6, re-enable at edge 10 -> TL=1 at edge 4, frozen through edge 10, TL=2 at edge 12.
- Store TL=7 in the same edge as a tick -> TL reads 7; store TH=9 during reload -> TL reads 9.
- With TIMER_SYSTICK_EN, release reset and load BASE+C after 100 edges -> 100; without the macro -> 0. An unmapped load returns 0 and a store to BASE+C changes nothing.
